// File: rtl/block_port_arbiter16_pkg.sv
// Shared constants for the 16-way block port arbiter.
// Holds FSM state encodings and requester count/index width.
package block_port_arbiter16_pkg;

    localparam int NUM_REQ = 16;
    localparam int IDX_W   = 4;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BUSY    = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

endpackage

// File: rtl/block_port_arbiter16_rr_priority_pick16.sv
// Combinational round-robin pick: first set req bit at ptr, ptr+1, ... mod 16.
// Ports: req[15:0], ptr[3:0] in; valid, win[3:0] out.
module rr_priority_pick16
    import block_port_arbiter16_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   win
);

    logic [IDX_W-1:0] idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        valid = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = ptr + i[IDX_W-1:0];
            if (req[idx]) begin
                valid = 1'b1;
                win   = idx;
            end
        end
    end

endmodule

// File: rtl/block_port_arbiter16.sv
// Round-robin arbiter/sequencer for the shared 128-bit block port.
// Ports: clk, reset (sync, high), req[15:0], mem_done in;
// grant[15:0], select[3:0], mem_req, ack[15:0], error out.
// Optional watchdog: define ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module block_port_arbiter16
    import block_port_arbiter16_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   select,
    output logic               mem_req,
    input  logic               mem_done,
    output logic [NUM_REQ-1:0] ack,
    output logic               error
);

    logic [1:0]       state;
    logic [IDX_W-1:0] ptr;
    logic             pick_valid;
    logic [IDX_W-1:0] pick_win;
    logic             finish;

    rr_priority_pick16 u_pick (
        .req   (req),
        .ptr   (ptr),
        .valid (pick_valid),
        .win   (pick_win)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt;
    logic             expire;
    logic             err_q;

    assign expire = (cnt == CNT_LAST);
    assign finish = mem_done || expire;
    assign error  = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else if (state == BUSY) begin
            cnt <= cnt + 1'b1;
            // A real completion on the expiry cycle is not a timeout.
            if (expire && !mem_done)
                err_q <= 1'b1;
        end else begin
            cnt <= '0;
        end
    end
`else
    assign finish = mem_done;
    // Parameter is only meaningful with the watchdog built in.
    assign error  = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            grant   <= '0;
            select  <= '0;
            mem_req <= 1'b0;
            ack     <= '0;
        end else begin
            ack <= '0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant   <= NUM_REQ'(1) << pick_win;
                        select  <= pick_win;
                        mem_req <= 1'b1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (finish) begin
                        // grant is still one-hot for the winner here.
                        ack     <= grant;
                        grant   <= '0;
                        mem_req <= 1'b0;
                        ptr     <= select + 1'b1;
                        state   <= RELEASE;
                    end
                end
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_block_port_arbiter16.sv
// Directed self-checking bench for block_port_arbiter16.
// Define ARB_TIMEOUT_EN to also exercise the watchdog (limit 8).
module tb_block_port_arbiter16;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic [15:0] grant;
    logic [3:0]  select;
    logic        mem_req;
    logic        mem_done;
    logic [15:0] ack;
    logic        error;

    int nchecks = 0;
    int nerrs   = 0;
    int cyc     = 0;
    int last_g  = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    block_port_arbiter16 #(
        .TIMEOUT_CYCLES (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .grant    (grant),
        .select   (select),
        .mem_req  (mem_req),
        .mem_done (mem_done),
        .ack      (ack),
        .error    (error)
    );

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        nchecks++;
        if (got !== exp) begin
            nerrs++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_outs(input string tag);
        check({tag, " grant"}, 32'(grant), 32'h0);
        check({tag, " mem_req"}, 32'(mem_req), 32'h0);
        check({tag, " ack"}, 32'(ack), 32'h0);
    endtask

    // One transaction; req is left as given.
    task automatic txn(input logic [15:0] r, input int lat,
                       input logic [3:0] w, input string tag);
        logic [15:0] oh;
        oh  = 16'h1 << w;
        req = r;
        tick();
        check({tag, " grant"}, 32'(grant), 32'(oh));
        check({tag, " select"}, 32'(select), 32'(w));
        check({tag, " mem_req"}, 32'(mem_req), 32'h1);
        last_g = cyc;
        repeat (lat - 1) begin
            tick();
            check({tag, " hold"}, 32'(grant), 32'(oh));
        end
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check({tag, " ack"}, 32'(ack), 32'(oh));
        check({tag, " grant off"}, 32'(grant), 32'h0);
        check({tag, " mem_req off"}, 32'(mem_req), 32'h0);
        tick();
        check({tag, " ack off"}, 32'(ack), 32'h0);
    endtask

    initial begin
        int prev;
        reset    = 1'b1;
        req      = '0;
        mem_done = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        idle_outs("reset");
        check("reset select", 32'(select), 32'h0);
        check("reset error", 32'(error), 32'h0);
        check("reset ptr", 32'(dut.ptr), 32'h0);

        for (int i = 0; i < 10; i++) begin
            tick();
            idle_outs("noreq");
            check("noreq select", 32'(select), 32'h0);
        end

        txn(16'h0020, 4, 4'd5, "single");
        req = '0;
        check("single ptr", 32'(dut.ptr), 32'h6);
        tick();
        idle_outs("single idle");
        check("select kept", 32'(select), 32'h5);

        // ptr=6: bit 0 comes before bit 5 in the search.
        txn(16'h0021, 1, 4'd0, "ptr6");
        req = '0;
        tick();

        reset = 1'b1;
        tick();
        reset = 1'b0;
        prev = -1;
        for (int i = 0; i < 17; i++) begin
            txn(16'hFFFF, 1, 4'(i % 16), "fair");
            if (prev >= 0)
                check("fair period", 32'(last_g - prev), 32'd3);
            prev = last_g;
        end
        req = '0;
        tick();

        txn(16'h2000, 2, 4'd13, "g13");
        check("ptr14", 32'(dut.ptr), 32'd14);
        txn(16'h0009, 2, 4'd0, "wrap0");
        txn(16'h0009, 2, 4'd3, "skip3");
        txn(16'h0009, 2, 4'd0, "again0");
        req = '0;
        tick();

        req = 16'h0100;
        tick();
        check("wd grant", 32'(grant), 32'h0100);
        req = '0;
        tick();
        check("wd hold", 32'(grant), 32'h0100);
        mem_done = 1'b1;
        tick();
        mem_done = 1'b0;
        check("wd ack", 32'(ack), 32'h0100);
        tick();

        req = 16'h0001;
        tick();
        check("rst grant", 32'(grant), 32'h0001);
        reset = 1'b1;
        req   = '0;
        tick();
        reset = 1'b0;
        idle_outs("rst busy");
        check("rst select", 32'(select), 32'h0);
        check("rst ptr", 32'(dut.ptr), 32'h0);
        tick();
        check("rst no ack", 32'(ack), 32'h0);
        check("rst error", 32'(error), 32'h0);

`ifdef ARB_TIMEOUT_EN
        req = 16'h0010;
        tick();
        check("to grant", 32'(grant), 32'h0010);
        req = '0;
        for (int i = 1; i < 8; i++) begin
            tick();
            check("to wait ack", 32'(ack), 32'h0);
            check("to wait err", 32'(error), 32'h0);
        end
        tick();
        check("to ack", 32'(ack), 32'h0010);
        check("to error", 32'(error), 32'h1);
        check("to ptr", 32'(dut.ptr), 32'h5);
        repeat (4) begin
            tick();
            check("to sticky", 32'(error), 32'h1);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("to clear", 32'(error), 32'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 nchecks, nerrs);
        $finish;
    end

endmodule
